// File: rtl/inter_switch_pkg.sv
// Shared types, defaults and helpers for the multicast inter switch.
package inter_switch_pkg;

  localparam int unsigned DefNumIn      = 5;
  localparam int unsigned DefNumOut     = 8;
  localparam int unsigned DefDwidth     = 1536;
  localparam int unsigned DefTlastWidth = 12;

  // Widest tlast sideband the EOP helper accepts; callers zero-extend into it.
  localparam int unsigned MaxTlastWidth = 64;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  // Any set tlast bit marks the end of the packet.
  function automatic logic eop_of(input logic [MaxTlastWidth-1:0] last);
    return |last;
  endfunction

endpackage

// File: rtl/inter_switch_mc_if.sv
// Config, source and sink stream signals of the multicast inter switch.
interface inter_switch_mc_if #(
  parameter int unsigned NUM_IN      = inter_switch_pkg::DefNumIn,
  parameter int unsigned NUM_OUT     = inter_switch_pkg::DefNumOut,
  parameter int unsigned DWIDTH      = inter_switch_pkg::DefDwidth,
  parameter int unsigned TLAST_WIDTH = inter_switch_pkg::DefTlastWidth,
  parameter int unsigned SEL_W       = $clog2(NUM_IN)
);

  logic [SEL_W-1:0]              cfg_in_sel;
  logic [NUM_OUT-1:0]            cfg_out_mask;
  logic                          cfg_valid;
  logic                          cfg_ready;
  logic                          cfg_err;
  logic [NUM_IN*DWIDTH-1:0]      s_tdata;
  logic [NUM_IN*TLAST_WIDTH-1:0] s_tlast;
  logic [NUM_IN-1:0]             s_tvalid;
  logic [NUM_IN-1:0]             s_tready;
  logic [DWIDTH-1:0]             m_tdata;
  logic [TLAST_WIDTH-1:0]        m_tlast;
  logic [NUM_OUT-1:0]            m_tvalid;
  logic [NUM_OUT-1:0]            m_tready;
  logic                          busy;

  // Switch side.
  modport slave (
    input  cfg_in_sel, cfg_out_mask, cfg_valid, s_tdata, s_tlast, s_tvalid, m_tready,
    output cfg_ready, cfg_err, s_tready, m_tdata, m_tlast, m_tvalid, busy
  );

  // Environment side: config master, stream sources and sinks.
  modport master (
    output cfg_in_sel, cfg_out_mask, cfg_valid, s_tdata, s_tlast, s_tvalid, m_tready,
    input  cfg_ready, cfg_err, s_tready, m_tdata, m_tlast, m_tvalid, busy
  );

endinterface

// File: rtl/stream_fifo2.sv
// Two-entry stream FIFO; ready depends only on occupancy, so there is no
// combinational path from the output side to the input side.
module stream_fifo2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [Width-1:0] mem_q [2];
  logic             wptr_q, rptr_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign out_data_o  = out_valid_o ? mem_q[rptr_q] : '0;

  // Occupancy update; a push never happens while full.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= in_data_i;
        wptr_q        <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/inter_switch_mc.sv
// Multicast inter switch: one selected source is buffered and forked to a
// mask of sinks; routing is configured only between packets.
module inter_switch_mc
  import inter_switch_pkg::*;
#(
  parameter int unsigned NUM_IN      = DefNumIn,
  parameter int unsigned NUM_OUT     = DefNumOut,
  parameter int unsigned DWIDTH      = DefDwidth,
  parameter int unsigned TLAST_WIDTH = DefTlastWidth,
  parameter int unsigned SEL_W       = $clog2(NUM_IN)
) (
  input logic              clk,
  input logic              rst_n,
  inter_switch_mc_if.slave bus_io
);

  localparam int unsigned     PayW   = DWIDTH + TLAST_WIDTH;
  localparam logic [SEL_W:0]  NumInW = (SEL_W + 1)'(NUM_IN);

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [NUM_OUT-1:0]     mask_q, mask_d;
  logic [NUM_OUT-1:0]     done_q, done_d;
  logic                   cfg_err_q, cfg_err_d;

  logic                   cfg_ok;
  logic [DWIDTH-1:0]      src_data;
  logic [TLAST_WIDTH-1:0] src_last;
  logic [MaxTlastWidth-1:0] src_last_ext;
  logic                   src_valid, src_eop;
  logic                   fifo_in_ready, in_ready_run, push;
  logic [PayW-1:0]        head_data;
  logic                   head_valid, pop;
  logic [NUM_OUT-1:0]     m_valid, hs;

  assign cfg_ok = ({1'b0, bus_io.cfg_in_sel} < NumInW) && (bus_io.cfg_out_mask != '0);

  assign src_data  = bus_io.s_tdata[int'(sel_q)*DWIDTH +: DWIDTH];
  assign src_last  = bus_io.s_tlast[int'(sel_q)*TLAST_WIDTH +: TLAST_WIDTH];
  assign src_valid = bus_io.s_tvalid[sel_q];

  // Zero-extend the selected tlast for the shared EOP helper.
  always_comb begin
    src_last_ext                    = '0;
    src_last_ext[TLAST_WIDTH-1:0]   = src_last;
  end
  assign src_eop = eop_of(src_last_ext);

  assign in_ready_run = (state_q == StRun) & fifo_in_ready;
  assign push         = in_ready_run & src_valid;

  // Only the selected source sees ready, and only while running.
  always_comb begin
    bus_io.s_tready        = '0;
    bus_io.s_tready[sel_q] = in_ready_run;
  end

  stream_fifo2 #(
    .Width (PayW)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_data_i   ({src_data, src_last}),
    .in_valid_i  (push),
    .in_ready_o  (fifo_in_ready),
    .out_data_o  (head_data),
    .out_valid_o (head_valid),
    .out_ready_i (pop)
  );

  // Fork: each masked sink takes the head once; pop when none is outstanding.
  assign m_valid = {NUM_OUT{head_valid}} & mask_q & ~done_q;
  assign hs      = m_valid & bus_io.m_tready;
  assign pop     = head_valid & ((mask_q & ~(done_q | hs)) == '0);
  assign done_d  = pop ? '0 : (done_q | hs);

  assign bus_io.m_tvalid  = m_valid;
  assign bus_io.m_tdata   = head_data[PayW-1 -: DWIDTH];
  assign bus_io.m_tlast   = head_data[TLAST_WIDTH-1:0];
  assign bus_io.cfg_ready = (state_q == StIdle);
  assign bus_io.cfg_err   = cfg_err_q;
  assign bus_io.busy      = (state_q != StIdle);

  // Config acceptance and packet phase sequencing.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    mask_d    = mask_q;
    cfg_err_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus_io.cfg_valid) begin
          if (cfg_ok) begin
            sel_d   = bus_io.cfg_in_sel;
            mask_d  = bus_io.cfg_out_mask;
            state_d = StRun;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (push && src_eop) state_d = StDrain;
      end
      StDrain: begin
        if (!head_valid && (done_q == '0)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, routing and fork-tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      mask_q    <= '0;
      done_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      mask_q    <= mask_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_inter_switch_mc.sv
// Directed self-checking bench for inter_switch_mc.
module tb_inter_switch_mc;

  localparam int unsigned NI = 5;
  localparam int unsigned NO = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 12;
  localparam int unsigned SW = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inter_switch_mc_if #(
    .NUM_IN(NI), .NUM_OUT(NO), .DWIDTH(DW), .TLAST_WIDTH(TW), .SEL_W(SW)
  ) bus ();

  inter_switch_mc #(
    .NUM_IN(NI), .NUM_OUT(NO), .DWIDTH(DW), .TLAST_WIDTH(TW), .SEL_W(SW)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  logic [DW-1:0] rx [NO][$];

  // Record every sink handshake just before the edge that completes it.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int j = 0; j < int'(NO); j++) begin
        if (bus.m_tvalid[j] && bus.m_tready[j]) rx[j].push_back(bus.m_tdata);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [NO-1:0] rdy(input int mode);
    if (mode == 1) return 8'h81 | (((cyc % 3) == 0) ? 8'h04 : 8'h00);
    return '1;
  endfunction

  task automatic clear_rx();
    for (int j = 0; j < int'(NO); j++) rx[j].delete();
  endtask

  task automatic do_cfg(input int sel, input logic [NO-1:0] mask);
    bus.cfg_in_sel   = SW'(sel);
    bus.cfg_out_mask = mask;
    bus.cfg_valid    = 1'b1;
    tick();
    bus.cfg_valid    = 1'b0;
  endtask

  task automatic drive_beat(input int sel, input logic [DW-1:0] d, input logic last);
    bus.s_tvalid                = '0;
    bus.s_tdata                 = '0;
    bus.s_tlast                 = '0;
    bus.s_tvalid[sel]           = 1'b1;
    bus.s_tdata[sel*DW +: DW]   = d;
    bus.s_tlast[sel*TW +: TW]   = last ? 12'h001 : 12'h000;
  endtask

  task automatic send_pkt(input int sel, input int n, input logic [DW-1:0] base,
                          input int mode, output int stalls);
    int beat  = 0;
    int guard = 0;
    logic acc;
    stalls = 0;
    while (beat < n && guard < 400) begin
      bus.m_tready = rdy(mode);
      drive_beat(sel, base + DW'(beat), beat == n - 1);
      acc = bus.s_tready[sel];
      if (!acc) stalls++;
      tick();
      if (acc) beat++;
      guard++;
    end
    bus.s_tvalid = '0;
    check_eq("pkt_accept", beat, n);
  endtask

  task automatic wait_idle(input int mode, output int waited);
    waited = 0;
    while (bus.busy && waited < 400) begin
      bus.m_tready = rdy(mode);
      tick();
      waited++;
    end
    check_eq("idle_reached", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st;
    int w;
    int other;
    logic bad;

    bus.cfg_in_sel   = '0;
    bus.cfg_out_mask = '0;
    bus.cfg_valid    = 1'b0;
    bus.s_tdata      = '0;
    bus.s_tlast      = '0;
    bus.s_tvalid     = '0;
    bus.m_tready     = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check_eq("rst_cfg_ready", bus.cfg_ready, 1);
    check_eq("rst_cfg_err", bus.cfg_err, 0);
    check_eq("rst_s_tready", bus.s_tready, 0);
    check_eq("rst_m_tvalid", bus.m_tvalid, 0);
    check_eq("rst_m_tdata", bus.m_tdata, 0);
    check_eq("rst_m_tlast", bus.m_tlast, 0);
    check_eq("rst_busy", bus.busy, 0);

    // Unicast: source 2 -> sink 0, 4 beats
    clear_rx();
    bus.m_tready = '1;
    do_cfg(2, 8'h01);
    check_eq("uni_busy", bus.busy, 1);
    check_eq("uni_cfg_ready", bus.cfg_ready, 0);
    check_eq("uni_s_tready", bus.s_tready, 5'b00100);
    drive_beat(2, 32'hA0, 1'b0);
    tick();
    check_eq("uni_first_valid", bus.m_tvalid, 8'h01);
    check_eq("uni_first_data", bus.m_tdata, 32'hA0);
    send_pkt(2, 3, 32'hA1, 0, st);
    check_eq("uni_drain_ready", bus.s_tready, 0);
    wait_idle(0, w);
    check_eq("uni_busy_drop", w, 2);
    check_eq("uni_cfg_ready_back", bus.cfg_ready, 1);
    check_eq("uni_rx_len", rx[0].size(), 4);
    for (int i = 0; i < 4 && i < rx[0].size(); i++) check_eq("uni_rx_data", rx[0][i], 32'hA0 + i);
    other = 0;
    for (int j = 1; j < int'(NO); j++) other += rx[j].size();
    check_eq("uni_no_leak", other, 0);

    // Multicast with a slow sink 2
    clear_rx();
    do_cfg(1, 8'h85);
    send_pkt(1, 6, 32'hB0, 1, st);
    wait_idle(1, w);
    check_eq("mc_src_stalled", st > 0, 1);
    check_eq("mc_len_s0", rx[0].size(), 6);
    check_eq("mc_len_s2", rx[2].size(), 6);
    check_eq("mc_len_s7", rx[7].size(), 6);
    check_eq("mc_len_s1", rx[1].size(), 0);
    for (int i = 0; i < 6 && i < rx[2].size(); i++) check_eq("mc_s2_data", rx[2][i], 32'hB0 + i);
    for (int i = 0; i < 6 && i < rx[7].size(); i++) check_eq("mc_s7_data", rx[7][i], 32'hB0 + i);

    // Rejected configurations
    do_cfg(5, 8'h01);
    check_eq("bad_sel_err", bus.cfg_err, 1);
    check_eq("bad_sel_busy", bus.busy, 0);
    check_eq("bad_sel_s_tready", bus.s_tready, 0);
    tick();
    check_eq("bad_sel_err_pulse", bus.cfg_err, 0);
    do_cfg(7, 8'h01);
    check_eq("bad_sel7_err", bus.cfg_err, 1);
    tick();
    do_cfg(0, 8'h00);
    check_eq("bad_mask_err", bus.cfg_err, 1);
    check_eq("bad_mask_busy", bus.busy, 0);
    check_eq("bad_mask_s_tready", bus.s_tready, 0);
    tick();
    check_eq("bad_mask_err_pulse", bus.cfg_err, 0);

    // Config request held during a packet
    clear_rx();
    bus.m_tready = '1;
    do_cfg(0, 8'h02);
    bus.cfg_in_sel   = 3'd3;
    bus.cfg_out_mask = 8'h08;
    bus.cfg_valid    = 1'b1;
    check_eq("mid_cfg_ready", bus.cfg_ready, 0);
    send_pkt(0, 3, 32'hC0, 0, st);
    bad = 1'b0;
    w   = 0;
    while (bus.busy && w < 50) begin
      if (bus.cfg_ready) bad = 1'b1;
      tick();
      w++;
    end
    check_eq("mid_cfg_held_off", bad, 0);
    check_eq("mid_idle_ready", bus.cfg_ready, 1);
    tick();
    bus.cfg_valid = 1'b0;
    check_eq("mid_new_cfg_taken", bus.busy, 1);
    check_eq("mid_new_sel", bus.s_tready, 5'b01000);
    check_eq("mid_pkt1_len", rx[1].size(), 3);
    for (int i = 0; i < 3 && i < rx[1].size(); i++) check_eq("mid_pkt1_data", rx[1][i], 32'hC0 + i);
    check_eq("mid_s3_empty", rx[3].size(), 0);

    // Single-beat packet on the new route
    drive_beat(3, 32'hD0, 1'b1);
    tick();
    bus.s_tvalid = '0;
    check_eq("one_drain_ready", bus.s_tready, 0);
    check_eq("one_busy1", bus.busy, 1);
    check_eq("one_valid", bus.m_tvalid, 8'h08);
    check_eq("one_data", bus.m_tdata, 32'hD0);
    check_eq("one_last", bus.m_tlast, 12'h001);
    tick();
    check_eq("one_busy2", bus.busy, 1);
    check_eq("one_popped", bus.m_tvalid, 0);
    tick();
    check_eq("one_idle", bus.busy, 0);

    // Back-to-back 64 beats at full rate
    clear_rx();
    do_cfg(4, 8'h01);
    send_pkt(4, 64, 32'h1000, 0, st);
    check_eq("b2b_stalls", st, 0);
    wait_idle(0, w);
    check_eq("b2b_busy_drop", w, 2);
    check_eq("b2b_len", rx[0].size(), 64);
    bad = 1'b0;
    for (int i = 0; i < 64 && i < rx[0].size(); i++) if (rx[0][i] !== 32'h1000 + i) bad = 1'b1;
    check_eq("b2b_order", bad, 0);

    // Asynchronous reset during drain with two beats buffered
    clear_rx();
    bus.m_tready = '0;
    do_cfg(0, 8'h01);
    drive_beat(0, 32'hE0, 1'b0);
    tick();
    drive_beat(0, 32'hE1, 1'b1);
    tick();
    bus.s_tvalid = '0;
    check_eq("arst_pre_ready", bus.s_tready, 0);
    check_eq("arst_pre_valid", bus.m_tvalid, 8'h01);
    check_eq("arst_pre_data", bus.m_tdata, 32'hE0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid_drop", bus.m_tvalid, 0);
    check_eq("arst_data_zero", bus.m_tdata, 0);
    check_eq("arst_busy", bus.busy, 0);
    tick();
    rst_n        = 1'b1;
    bus.m_tready = '1;
    tick();
    tick();
    tick();
    check_eq("arst_no_stale", rx[0].size(), 0);
    check_eq("arst_post_valid", bus.m_tvalid, 0);
    check_eq("arst_post_busy", bus.busy, 0);
    check_eq("arst_post_cfg_ready", bus.cfg_ready, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
